seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial bit-sequence detector and the next generation of the team's 2-state "din-pulse" FSM.
- Matches a runtime-programmable W-bit pattern on a qualified serial stream.
- Selectable overlap/non-overlap matching and Mealy/Moore output timing, plus a saturating match counter.
- Sits beside the DUT stimulus path in coverage/verification example benches, and doubles as a reusable RTL pattern-spotter.

Parameters:
W, 4, pattern length in bits (legal range 2..16).
MOORE, 0, 0 = Mealy (dout combinational, same cycle as the last matching bit); 1 = Moore (dout registered, one cycle later).
CNT_W, 8, width of match_cnt.
PATTERN_INIT, 4'b1011, pattern value after reset.
OVERLAP_INIT, 1, overlap mode after reset.

Ports:
clk  in  1  system clock; all state on posedge.
rst  in  1  synchronous, active-high reset.
din_valid  in  1  qualifies din; bit consumed only when high.
din  in  1  serial data bit.
cfg_load  in  1  one-cycle pulse; latches cfg_pattern/cfg_overlap and clears history.
cfg_pattern  in  W  new pattern; bit W-1 is the first bit received, bit 0 the last.
cfg_overlap  in  1  new overlap mode.
dout  out  1  match pulse, one cycle wide per match.
match_cnt  out  CNT_W  saturating count of matches.
busy_fill  out  clog2(W+1)  number of valid history bits, saturating at W-1 (debug).

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high (clk, rst).
  - Under rst: history=0, fill=0, match_cnt=0, Moore dout register=0, pattern_q=PATTERN_INIT, overlap_q=OVERLAP_INIT.
  - In Mealy mode dout=0 whenever rst=1.
- History:
  - W-1 bit shift register. The newest bit enters at the LSB on each accepted bit (din_valid=1, cfg_load=0).
  - fill increments per accepted bit and saturates at W-1.
- Match condition (comb): hit = din_valid & ~cfg_load & ~rst & (fill==W-1) & ({hist[W-2:0],din}==pattern_q).
- Effect of hit:
  - match_cnt increments, saturating at 2^CNT_W-1. It never wraps.
  - Overlap mode: history shifts normally and fill stays at W-1.
  - Non-overlap mode: fill is cleared to 0. The matching bit is not reused.
- Output timing:
  - MOORE=0: dout=hit.
  - MOORE=1: dout_q<=hit, so dout asserts exactly one cycle after the last pattern bit.
- din_valid=0: history, fill and counter hold. Gaps never break a partial match.
- cfg_load:
  - Latches pattern/overlap and clears history and fill. The same-cycle din bit is discarded and no hit occurs.
  - match_cnt is not cleared.
  - Moore dout from the previous cycle's hit still appears.
- Reset mid-sequence: partial matches are lost. The first match needs W fresh accepted bits after rst deasserts.
- Pattern states are implicit (fill 0..W-1 plus history), so no enumerated per-pattern FSM is required.
- Boundary rules:
  - W=2 is legal: history is 1 bit.
  - An all-zero or all-one pattern in overlap mode yields back-to-back hits every accepted bit once fill is saturated.

Decomposition:
- Package seq_det_pkg:
  - Output-mode constants MODE_MEALY=0 and MODE_MOORE=1.
  - Function for fill width, clog2(W+1).
  - Default pattern constant.
- Sub-module seq_det_hist: history shift register plus fill counter with shift/clear controls.
- Top level holds the config registers, comparator, counter and output stage.

Test Plan:
1. W=3, pattern 101, overlap=1, Mealy; bits 1,0,1,0,1 all valid -> dout high in the same cycle as bits 3 and 5; match_cnt=2.
2. Same stream with overlap=0 -> dout only on bit 3; match_cnt=1; fill=2 after bit 5.
3. W=3, pattern 101, MOORE=1; bits 1,0,1 -> dout low on bit 3's cycle and high for exactly one cycle after it.
4. Pattern 101 with din_valid low for 3 cycles between each bit -> still exactly one match; dout never asserts during gaps.
5. Stream 1,0 then rst for one cycle, then 1 -> no match; the sequence 1,0,1 afterwards -> match; match_cnt=1.
6. CNT_W=2, pattern 11, overlap=1, five consecutive 1s -> four hits, match_cnt saturates at 3. cfg_load to pattern 00 in the same cycle as din=1 -> bit discarded, fill=0, match_cnt stays 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// Imported by the history sub-module and the top level.
package seq_det_pkg;

    localparam bit MODE_MEALY = 1'b0;
    localparam bit MODE_MOORE = 1'b1;

    // Reset pattern for the default W=4 build; wider builds zero-extend.
    localparam logic [15:0] DEFAULT_PATTERN = 16'h000B;

    // Width needed to count 0..w inclusive.
    function automatic int fill_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register (W-1 newest accepted bits, newest at LSB) plus a
// saturating fill counter of how many of those bits are meaningful.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic                      din,
    input  logic                      clear_all,
    input  logic                      fill_clr,
    output logic [W-2:0]              hist,
    output logic [fill_width(W)-1:0]  fill
);

    localparam int FW = fill_width(W);
    localparam logic [FW-1:0] FILL_MAX = FW'(W - 1);

    logic [W-2:0]  hist_q;
    logic [W-2:0]  hist_d;
    logic [W-2:0]  shifted_s;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    // A one-bit history (W=2) is simply replaced by the incoming bit.
    if (W == 2) begin : g_w2
        assign shifted_s = din;
    end else begin : g_wn
        assign shifted_s = {hist_q[W-3:0], din};
    end

    // Next history/fill: clear beats shift; a non-overlap hit restarts fill.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_all) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = shifted_s;
            if (fill_clr) begin
                fill_d = '0;
            end else if (fill_q == FILL_MAX) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FW'(1);
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable W-bit serial pattern detector with overlap/non-overlap
// matching, Mealy or Moore pulse timing and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int           W            = 4,
    parameter bit           MOORE        = MODE_MEALY,
    parameter int           CNT_W        = 8,
    parameter logic [W-1:0] PATTERN_INIT = DEFAULT_PATTERN[W-1:0],
    parameter bit           OVERLAP_INIT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic                      din,
    input  logic                      cfg_load,
    input  logic [W-1:0]              cfg_pattern,
    input  logic                      cfg_overlap,
    output logic                      dout,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [fill_width(W)-1:0]  busy_fill
);

    localparam int FW = fill_width(W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [W-1:0]     pattern_q;
    logic [W-1:0]     pattern_d;
    logic             overlap_q;
    logic             overlap_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    logic [W-2:0]     hist_s;
    logic [FW-1:0]    fill_s;
    logic             hit_s;
    logic             fill_clr_s;

    seq_det_hist #(
        .W (W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (din_valid),
        .din       (din),
        .clear_all (cfg_load),
        .fill_clr  (fill_clr_s),
        .hist      (hist_s),
        .fill      (fill_s)
    );

    // Match on the bit being presented now; rst gates it so Mealy dout is
    // quiet during reset even though state is only cleared at the edge.
    always_comb begin
        hit_s      = din_valid & ~cfg_load & ~rst & (fill_s == FILL_MAX) &
                     ({hist_s, din} == pattern_q);
        fill_clr_s = hit_s & ~overlap_q;
    end

    // Config capture, saturating counter and Moore pulse next-state.
    always_comb begin
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        cnt_d     = cnt_q;
        dout_d    = hit_s;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
        end else begin
            pattern_d = pattern_q;
            overlap_d = overlap_q;
        end
        if (hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Configuration, counter and Moore output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PATTERN_INIT;
            overlap_q <= OVERLAP_INIT;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
        end
    end

    // Output timing select.
    always_comb begin
        if (MOORE == MODE_MOORE) begin
            dout = dout_q;
        end else begin
            dout = hit_s;
        end
    end

    assign match_cnt = cnt_q;
    assign busy_fill = fill_s;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three builds (W=3 Mealy, W=3 Moore, W=2 with a
// 2-bit counter) share one stimulus stream and are checked against a model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       cfg_load = 1'b0;
    logic       cfg_overlap = 1'b1;
    logic [2:0] cfg_pattern3 = 3'b101;
    logic [1:0] cfg_pattern2 = 2'b11;

    logic       dout_a, dout_b, dout_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] fill_a, fill_b, fill_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.W(3), .MOORE(1'b0), .CNT_W(8), .PATTERN_INIT(3'b101), .OVERLAP_INIT(1'b1)) u_a (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap),
        .dout(dout_a), .match_cnt(cnt_a), .busy_fill(fill_a));

    seq_detect_param #(.W(3), .MOORE(1'b1), .CNT_W(8), .PATTERN_INIT(3'b101), .OVERLAP_INIT(1'b1)) u_b (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap),
        .dout(dout_b), .match_cnt(cnt_b), .busy_fill(fill_b));

    seq_detect_param #(.W(2), .MOORE(1'b0), .CNT_W(2), .PATTERN_INIT(2'b11), .OVERLAP_INIT(1'b1)) u_c (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern2), .cfg_overlap(cfg_overlap),
        .dout(dout_c), .match_cnt(cnt_c), .busy_fill(fill_c));

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: each build remembers the accepted bits since its last clear as
    // a number plus a count; a match is the newest W bits equalling the pattern.
    int     mw[3]    = '{3, 3, 2};
    bit     mmoore[3] = '{1'b0, 1'b1, 1'b0};
    int     mcmax[3] = '{255, 255, 3};
    int     minit[3] = '{5, 5, 3};
    longint mbits[3];
    int     mcount[3];
    int     mpat[3];
    bit     movl[3];
    int     mcnt[3];
    bit     mprev[3];
    bit     started = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                int ad[3];
                int ac[3];
                int af[3];
                ad = '{int'(dout_a), int'(dout_b), int'(dout_c)};
                ac = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
                af = '{int'(fill_a), int'(fill_b), int'(fill_c)};
                for (int i = 0; i < 3; i++) begin
                    longint mask;
                    longint cand;
                    int     cfgp;
                    bit     h;
                    mask = (longint'(1) << mw[i]) - 1;
                    cand = ((mbits[i] << 1) | longint'(din)) & mask;
                    cfgp = (i < 2) ? int'(cfg_pattern3) : int'(cfg_pattern2);
                    h = !rst && din_valid && !cfg_load && (mcount[i] >= mw[i] - 1) &&
                        (cand == longint'(mpat[i]));
                    if (started) begin
                        check($sformatf("dout[%0d]", i), ad[i], mmoore[i] ? int'(mprev[i]) : int'(h));
                        check($sformatf("match_cnt[%0d]", i), ac[i], mcnt[i]);
                        check($sformatf("busy_fill[%0d]", i), af[i],
                              (mcount[i] < mw[i] - 1) ? mcount[i] : mw[i] - 1);
                    end
                    if (rst) begin
                        mbits[i] = 0; mcount[i] = 0; mpat[i] = minit[i];
                        movl[i] = 1'b1; mcnt[i] = 0; mprev[i] = 1'b0;
                    end else if (cfg_load) begin
                        mbits[i] = 0; mcount[i] = 0; mpat[i] = cfgp;
                        movl[i] = cfg_overlap; mprev[i] = 1'b0;
                    end else begin
                        if (din_valid) begin
                            if (h && mcnt[i] < mcmax[i]) mcnt[i]++;
                            if (h && !movl[i]) begin
                                mbits[i] = 0;
                                mcount[i] = 0;
                            end else begin
                                mbits[i] = ((mbits[i] << 1) | longint'(din)) & 64'hFFFF;
                                mcount[i]++;
                            end
                        end
                        mprev[i] = h;
                    end
                end
                if (rst) started = 1'b1;
            end
        end
    end

    task automatic drive(input logic r, input logic l, input logic v, input logic d);
        @(posedge clk);
        #2;
        rst = r; cfg_load = l; din_valid = v; din = d;
    endtask

    task automatic bitin(input logic d);
        drive(1'b0, 1'b0, 1'b1, d);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
        #1;
    endtask

    task automatic load(input logic [2:0] p3, input logic [1:0] p2, input logic ovl, input logic d);
        @(posedge clk);
        #2;
        rst = 1'b0; cfg_load = 1'b1; din_valid = 1'b1; din = d;
        cfg_pattern3 = p3; cfg_pattern2 = p2; cfg_overlap = ovl;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        idle();
        check("reset cnt_a", int'(cnt_a), 0);
        check("reset fill_a", int'(fill_a), 0);
        check("reset dout_b", int'(dout_b), 0);

        // Overlap Mealy 101 on 1,0,1,0,1; Moore build lags by one cycle.
        bitin(1'b1); bitin(1'b0); bitin(1'b1);
        check("t1 bit3 dout_a", int'(dout_a), 1);
        check("t3 bit3 dout_b", int'(dout_b), 0);
        bitin(1'b0);
        check("t1 bit4 dout_a", int'(dout_a), 0);
        check("t3 bit4 dout_b", int'(dout_b), 1);
        bitin(1'b1);
        check("t1 bit5 dout_a", int'(dout_a), 1);
        check("t3 bit5 dout_b", int'(dout_b), 0);
        idle();
        check("t1 cnt_a", int'(cnt_a), 2);
        check("t1 fill_a", int'(fill_a), 2);

        // Non-overlap on the same stream.
        do_reset();
        load(3'b101, 2'b11, 1'b0, 1'b0);
        bitin(1'b1); bitin(1'b0); bitin(1'b1);
        check("t2 bit3 dout_a", int'(dout_a), 1);
        bitin(1'b0); bitin(1'b1);
        check("t2 bit5 dout_a", int'(dout_a), 0);
        idle();
        check("t2 cnt_a", int'(cnt_a), 1);
        check("t2 fill_a", int'(fill_a), 2);

        // Gaps between bits do not break a partial match.
        do_reset();
        bitin(1'b1); idle(); idle(); idle();
        bitin(1'b0); idle(); idle(); idle();
        bitin(1'b1);
        check("t4 dout_a", int'(dout_a), 1);
        idle(); idle(); idle();
        check("t4 cnt_a", int'(cnt_a), 1);

        // Reset mid-sequence loses the partial match.
        do_reset();
        bitin(1'b1); bitin(1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        bitin(1'b1);
        check("t5 post-rst dout_a", int'(dout_a), 0);
        bitin(1'b0); bitin(1'b1);
        check("t5 match dout_a", int'(dout_a), 1);
        idle();
        check("t5 cnt_a", int'(cnt_a), 1);

        // W=2 pattern 11: saturation, then load of 00 discarding its bit.
        do_reset();
        bitin(1'b1); bitin(1'b1); bitin(1'b1); bitin(1'b1); bitin(1'b1);
        check("t6 bit5 dout_c", int'(dout_c), 1);
        load(3'b111, 2'b00, 1'b1, 1'b1);
        check("t6 load dout_c", int'(dout_c), 0);
        idle();
        check("t6 cnt_c", int'(cnt_c), 3);
        check("t6 fill_c", int'(fill_c), 0);
        bitin(1'b0);
        check("t6 zero1 dout_c", int'(dout_c), 0);
        bitin(1'b0);
        check("t6 zero2 dout_c", int'(dout_c), 1);
        bitin(1'b0);
        check("t6 zero3 dout_c", int'(dout_c), 1);
        idle();
        check("t6 cnt_c sat", int'(cnt_c), 3);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
